sequencer_ws: RTL and testbench
===============================

# sequencer_ws

Parametrised multi-cycle control sequencer for the accumulator processor, and the successor to the fixed-timing sequencer. It adds:
- a memory ready/wait-state handshake;
- BEQ, JMP, NOP and HALT instructions;
- illegal-opcode trapping;
- an optional memory-access watchdog.

It sits between the instruction register opcode field and the datapath/memory control strobes.

## Interface
Parameters:
- WORD_W, 8, datapath word width; passed through for consistency, does not affect control logic.
- OP_W, 4, opcode width; must be ≥ 4.
- TMO_W, 4, watchdog counter width; effective only with SEQ_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge
- n_reset  in  1  reset, asynchronous, active-low; clock is clock
- op  in  OP_W  opcode from IR; sampled in DECODE and in the states that follow it
- z_flag  in  1  accumulator-zero flag
- mem_ready  in  1  memory completes the current access at this edge; ignored while CS=0
- ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR  out  1 each  datapath strobes
- ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_comp  out  1 each  ALU controls
- INC_PC, Addr_bus  out  1 each  PC increment; IR address field onto bus
- CS, R_NW  out  1 each  memory select; 1 = read
- halted  out  1  high in HALT state
- fault  out  1  high in FAULT state

## Operation
- All outputs are combinational from the state (and from op/z_flag where stated). Every output defaults to 0.
- States and the outputs asserted in each:
  - FETCH: PC_bus, load_MAR, INC_PC, load_PC → F_RD.
  - F_RD: CS, R_NW. Stays until mem_ready=1, then → F_IR.
  - F_IR: MDR_bus, load_IR → DECODE.
  - DECODE: Addr_bus, load_MAR. Next state by op:
    - STORE → ST_DAT
    - LOAD/ADD/SUB/XOR/COMP/BNE/BEQ → EX_RD
    - JMP → JUMP
    - NOP → FETCH
    - HALT → HALTED
    - any other code → FAULT
  - ST_DAT: ACC_bus, load_MDR → ST_WR.
  - ST_WR: CS (R_NW=0). Stays until mem_ready=1, then → FETCH.
  - EX_RD: CS, R_NW. Stays until mem_ready=1. Then LOAD → EX_LD; BNE with z_flag=0 or BEQ with z_flag=1 → BR_TK; BNE/BEQ otherwise → FETCH; ALU ops → EX_ALU.
  - EX_LD: MDR_bus, load_ACC → FETCH.
  - EX_ALU: MDR_bus, ALU_ACC, load_ACC, plus exactly one of ALU_add/sub/xor/comp decoded from op → FETCH.
  - BR_TK: MDR_bus, load_PC → FETCH. Branch target is the memory word (indirect).
  - JUMP: Addr_bus, load_PC → FETCH. Target is the IR address field (direct).
  - HALTED: halted=1. Terminal until reset.
  - FAULT: fault=1. Terminal until reset.
- Opcodes: LOAD 0, STORE 1, ADD 2, SUB 3, XOR 4, COMP 5, BNE 6, BEQ 7, JMP 8, NOP 9, HALT 15. Codes 10–14 are illegal. For OP_W>4, any code above 15 is also illegal.
- z_flag is sampled only in the EX_RD cycle in which mem_ready=1.
- CS and R_NW remain stable for every cycle of a wait.

## Timing
- Reset: state FETCH, all outputs 0 except FETCH's combinational strobes (PC_bus, load_MAR, INC_PC, load_PC = 1 while in FETCH). Watchdog count = 0.
- Instruction length with mem_ready tied high:
  - NOP: 4 cycles
  - JMP: 5 cycles
  - branch not taken: 5 cycles
  - LOAD, STORE, ALU ops, branch taken: 6 cycles
- Each cycle with mem_ready=0 in F_RD, ST_WR or EX_RD adds exactly one cycle.
- mem_ready=1 in the first cycle of an access state completes that access with no added cycle.
- Reset asserted mid-access: immediate return to FETCH, with CS and R_NW low from the reset assertion onward.

## Configuration
SEQ_TIMEOUT_EN:
- Defined:
  - A TMO_W-bit counter clears on entry to each access state and increments each waiting cycle.
  - If the count reaches 2^TMO_W−1 while mem_ready=0, the next state is FAULT.
  - If mem_ready=1 arrives in that same cycle, the access completes normally.
- Undefined: no counter; waits are unbounded and FAULT is reachable only through an illegal opcode.

## Structure
- Package seq_pkg holds:
  - opcode localparams
  - the state enum type (FETCH…FAULT)
  - the illegal-opcode predicate function
- One sub-module, seq_watchdog (counter with clear/enable/expired), instantiated only under SEQ_TIMEOUT_EN.

## Test plan
- LOAD with mem_ready always 1 → 6 cycles FETCH→F_RD→F_IR→DECODE→EX_RD→EX_LD, load_ACC high in cycle 6 only.
- STORE with mem_ready low for 3 cycles in ST_WR → CS=1 and R_NW=0 held 4 cycles; instruction takes 9 cycles.
- BNE with z_flag=0 → BR_TK, load_PC plus MDR_bus. BEQ with z_flag=0 → FETCH after 5 cycles, load_PC never asserted after FETCH.
- op=12 → FAULT one cycle after DECODE, fault=1 held; op=15 → halted=1; both clear only on n_reset.
- With SEQ_TIMEOUT_EN and TMO_W=2, mem_ready held 0 in F_RD → FAULT after 4 F_RD cycles. With mem_ready=1 on the 4th cycle → F_IR.
- n_reset pulsed during an EX_RD wait → outputs go to FETCH values asynchronously; fetch restarts cleanly after release.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared opcode encodings, state type and opcode legality check for the
// wait-state sequencer.
package seq_pkg;

    localparam int unsigned OP_LOAD  = 0;
    localparam int unsigned OP_STORE = 1;
    localparam int unsigned OP_ADD   = 2;
    localparam int unsigned OP_SUB   = 3;
    localparam int unsigned OP_XOR   = 4;
    localparam int unsigned OP_COMP  = 5;
    localparam int unsigned OP_BNE   = 6;
    localparam int unsigned OP_BEQ   = 7;
    localparam int unsigned OP_JMP   = 8;
    localparam int unsigned OP_NOP   = 9;
    localparam int unsigned OP_HALT  = 15;

    typedef enum logic [3:0] {
        FETCH,
        F_RD,
        F_IR,
        DECODE,
        ST_DAT,
        ST_WR,
        EX_RD,
        EX_LD,
        EX_ALU,
        BR_TK,
        JUMP,
        HALTED,
        FAULT
    } state_t;

    // Codes 10..14 and anything above 15 (wide opcode fields) have no meaning.
    function automatic logic is_illegal_op(input int unsigned code);
        return ((code >= 10) && (code <= 14)) || (code > 15);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Memory-access watchdog: counts waiting cycles, flags when the count saturates.
// Only instantiated when SEQ_TIMEOUT_EN is defined.
module seq_watchdog #(
    parameter int unsigned TMO_W = 4
) (
    input  logic clock,
    input  logic n_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == {TMO_W{1'b1}});

endmodule

// File: rtl/sequencer_ws.sv
// Multi-cycle control sequencer with memory wait states, BEQ/JMP/NOP/HALT and
// illegal-opcode trap. Define SEQ_TIMEOUT_EN to add the memory-access watchdog.
module sequencer_ws
    import seq_pkg::*;
#(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned TMO_W  = 4
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            load_IR,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            ALU_xor,
    output logic            ALU_comp,
    output logic            INC_PC,
    output logic            Addr_bus,
    output logic            CS,
    output logic            R_NW,
    output logic            halted,
    output logic            fault
);

    if (OP_W < 4) begin : g_bad_op_w
        $error("sequencer_ws: OP_W must be at least 4");
    end
    if (WORD_W < 1 || TMO_W < 1) begin : g_bad_w
        $error("sequencer_ws: WORD_W and TMO_W must be non-zero");
    end

    state_t      state, state_next;
    int unsigned op_val;
    logic        in_access;
    logic        wd_expired;

    assign op_val    = 32'(op);
    assign in_access = (state == F_RD) || (state == ST_WR) || (state == EX_RD);

`ifdef SEQ_TIMEOUT_EN
    // Counter is held clear outside access states, so it restarts on every entry.
    seq_watchdog #(
        .TMO_W(TMO_W)
    ) u_watchdog (
        .clock  (clock),
        .n_reset(n_reset),
        .clear  (!in_access),
        .enable (in_access && !mem_ready),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: state_next = F_RD;
            F_RD: begin
                if (mem_ready)       state_next = F_IR;
                else if (wd_expired) state_next = FAULT;
            end
            F_IR: state_next = DECODE;
            DECODE: begin
                if (is_illegal_op(op_val)) begin
                    state_next = FAULT;
                end else begin
                    case (op_val)
                        OP_STORE: state_next = ST_DAT;
                        OP_JMP:   state_next = JUMP;
                        OP_NOP:   state_next = FETCH;
                        OP_HALT:  state_next = HALTED;
                        default:  state_next = EX_RD;
                    endcase
                end
            end
            ST_DAT: state_next = ST_WR;
            ST_WR: begin
                if (mem_ready)       state_next = FETCH;
                else if (wd_expired) state_next = FAULT;
            end
            EX_RD: begin
                if (mem_ready) begin
                    case (op_val)
                        OP_LOAD: state_next = EX_LD;
                        OP_BNE:  state_next = z_flag ? FETCH : BR_TK;
                        OP_BEQ:  state_next = z_flag ? BR_TK : FETCH;
                        OP_ADD, OP_SUB, OP_XOR, OP_COMP: state_next = EX_ALU;
                        default: state_next = FAULT;
                    endcase
                end else if (wd_expired) begin
                    state_next = FAULT;
                end
            end
            EX_LD, EX_ALU, BR_TK, JUMP: state_next = FETCH;
            HALTED: state_next = HALTED;
            FAULT:  state_next = FAULT;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        ACC_bus  = 1'b0;
        load_ACC = 1'b0;
        PC_bus   = 1'b0;
        load_PC  = 1'b0;
        load_IR  = 1'b0;
        load_MAR = 1'b0;
        MDR_bus  = 1'b0;
        load_MDR = 1'b0;
        ALU_ACC  = 1'b0;
        ALU_add  = 1'b0;
        ALU_sub  = 1'b0;
        ALU_xor  = 1'b0;
        ALU_comp = 1'b0;
        INC_PC   = 1'b0;
        Addr_bus = 1'b0;
        CS       = 1'b0;
        R_NW     = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state)
            FETCH: begin
                PC_bus   = 1'b1;
                load_MAR = 1'b1;
                INC_PC   = 1'b1;
                load_PC  = 1'b1;
            end
            F_RD, EX_RD: begin
                CS   = 1'b1;
                R_NW = 1'b1;
            end
            F_IR: begin
                MDR_bus = 1'b1;
                load_IR = 1'b1;
            end
            DECODE: begin
                Addr_bus = 1'b1;
                load_MAR = 1'b1;
            end
            ST_DAT: begin
                ACC_bus  = 1'b1;
                load_MDR = 1'b1;
            end
            ST_WR: CS = 1'b1;
            EX_LD: begin
                MDR_bus  = 1'b1;
                load_ACC = 1'b1;
            end
            EX_ALU: begin
                MDR_bus  = 1'b1;
                ALU_ACC  = 1'b1;
                load_ACC = 1'b1;
                ALU_add  = (op_val == OP_ADD);
                ALU_sub  = (op_val == OP_SUB);
                ALU_xor  = (op_val == OP_XOR);
                ALU_comp = (op_val == OP_COMP);
            end
            BR_TK: begin
                MDR_bus = 1'b1;
                load_PC = 1'b1;
            end
            JUMP: begin
                Addr_bus = 1'b1;
                load_PC  = 1'b1;
            end
            HALTED: halted = 1'b1;
            FAULT:  fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sequencer_ws.sv
// Self-checking bench for sequencer_ws: per-cycle expected strobe vectors are
// queued as stimulus is driven and compared on the falling edge.
module tb_sequencer_ws;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned TMO_W = 2;

    logic            clock;
    logic            n_reset;
    logic [OP_W-1:0] op;
    logic            z_flag;
    logic            mem_ready;
    logic ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR;
    logic ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_comp, INC_PC, Addr_bus;
    logic CS, R_NW, halted, fault;

    sequencer_ws #(
        .WORD_W(8),
        .OP_W  (OP_W),
        .TMO_W (TMO_W)
    ) dut (
        .clock    (clock),
        .n_reset  (n_reset),
        .op       (op),
        .z_flag   (z_flag),
        .mem_ready(mem_ready),
        .ACC_bus  (ACC_bus),
        .load_ACC (load_ACC),
        .PC_bus   (PC_bus),
        .load_PC  (load_PC),
        .load_IR  (load_IR),
        .load_MAR (load_MAR),
        .MDR_bus  (MDR_bus),
        .load_MDR (load_MDR),
        .ALU_ACC  (ALU_ACC),
        .ALU_add  (ALU_add),
        .ALU_sub  (ALU_sub),
        .ALU_xor  (ALU_xor),
        .ALU_comp (ALU_comp),
        .INC_PC   (INC_PC),
        .Addr_bus (Addr_bus),
        .CS       (CS),
        .R_NW     (R_NW),
        .halted   (halted),
        .fault    (fault)
    );

    logic [18:0] outs;
    assign outs = {ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR,
                   ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_comp, INC_PC, Addr_bus,
                   CS, R_NW, halted, fault};

    localparam logic [18:0] B_ACC_BUS  = 19'd1 << 18;
    localparam logic [18:0] B_LOAD_ACC = 19'd1 << 17;
    localparam logic [18:0] B_PC_BUS   = 19'd1 << 16;
    localparam logic [18:0] B_LOAD_PC  = 19'd1 << 15;
    localparam logic [18:0] B_LOAD_IR  = 19'd1 << 14;
    localparam logic [18:0] B_LOAD_MAR = 19'd1 << 13;
    localparam logic [18:0] B_MDR_BUS  = 19'd1 << 12;
    localparam logic [18:0] B_LOAD_MDR = 19'd1 << 11;
    localparam logic [18:0] B_ALU_ACC  = 19'd1 << 10;
    localparam logic [18:0] B_ADD      = 19'd1 << 9;
    localparam logic [18:0] B_SUB      = 19'd1 << 8;
    localparam logic [18:0] B_XOR      = 19'd1 << 7;
    localparam logic [18:0] B_COMP     = 19'd1 << 6;
    localparam logic [18:0] B_INC_PC   = 19'd1 << 5;
    localparam logic [18:0] B_ADDR_BUS = 19'd1 << 4;
    localparam logic [18:0] B_CS       = 19'd1 << 3;
    localparam logic [18:0] B_R_NW     = 19'd1 << 2;
    localparam logic [18:0] B_HALTED   = 19'd1 << 1;
    localparam logic [18:0] B_FAULT    = 19'd1 << 0;

    localparam logic [18:0] E_FETCH = B_PC_BUS | B_LOAD_MAR | B_INC_PC | B_LOAD_PC;
    localparam logic [18:0] E_RD    = B_CS | B_R_NW;
    localparam logic [18:0] E_WR    = B_CS;
    localparam logic [18:0] E_FIR   = B_MDR_BUS | B_LOAD_IR;
    localparam logic [18:0] E_DEC   = B_ADDR_BUS | B_LOAD_MAR;
    localparam logic [18:0] E_STDAT = B_ACC_BUS | B_LOAD_MDR;
    localparam logic [18:0] E_EXLD  = B_MDR_BUS | B_LOAD_ACC;
    localparam logic [18:0] E_ALU   = B_MDR_BUS | B_ALU_ACC | B_LOAD_ACC;
    localparam logic [18:0] E_BRTK  = B_MDR_BUS | B_LOAD_PC;
    localparam logic [18:0] E_JUMP  = B_ADDR_BUS | B_LOAD_PC;

    typedef struct {
        string       tag;
        logic [18:0] val;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            check_eq(e.tag, outs, e.val);
        end
    end

    // Drive one cycle (called at posedge+1) and queue the outputs expected in it.
    task automatic step(input string tag, input logic mr, input logic [18:0] exp);
        exp_t e;
        mem_ready = mr;
        e.tag = tag;
        e.val = exp;
        expq.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        #1;
        check_eq("reset_state", outs, E_FETCH);
        @(posedge clock);
        #1;
        n_reset = 1'b1;
    endtask

    function automatic logic [18:0] alu_bit(input int o);
        case (o)
            2:       return B_ADD;
            3:       return B_SUB;
            4:       return B_XOR;
            default: return B_COMP;
        endcase
    endfunction

    // One instruction from FETCH; fw/xw are wait cycles in the fetch and data accesses.
    task automatic run_instr(input int o, input logic z, input int fw, input int xw);
        logic rnd;
        op     = o[OP_W-1:0];
        z_flag = ~z;
        rnd    = 1'($urandom_range(0, 1));
        step($sformatf("op%0d_fetch", o), rnd, E_FETCH);
        for (int i = 0; i < fw; i++) step($sformatf("op%0d_frd_wait", o), 1'b0, E_RD);
        step($sformatf("op%0d_frd", o), 1'b1, E_RD);
        step($sformatf("op%0d_fir", o), rnd, E_FIR);
        step($sformatf("op%0d_decode", o), ~rnd, E_DEC);
        case (o)
            1: begin
                step("st_dat", rnd, E_STDAT);
                for (int i = 0; i < xw; i++) step("st_wr_wait", 1'b0, E_WR);
                step("st_wr", 1'b1, E_WR);
            end
            0, 2, 3, 4, 5, 6, 7: begin
                for (int i = 0; i < xw; i++) step($sformatf("op%0d_exrd_wait", o), 1'b0, E_RD);
                z_flag = z;
                step($sformatf("op%0d_exrd", o), 1'b1, E_RD);
                z_flag = ~z;
                if (o == 0) step("ex_ld", rnd, E_EXLD);
                else if (o == 6 && !z) step("bne_taken", rnd, E_BRTK);
                else if (o == 7 && z) step("beq_taken", rnd, E_BRTK);
                else if (o >= 2 && o <= 5) step($sformatf("alu_op%0d", o), rnd, E_ALU | alu_bit(o));
            end
            8: step("jump", rnd, E_JUMP);
            9: ;
            15: begin
                for (int i = 0; i < 3; i++) step("halted", rnd, B_HALTED);
                do_reset();
            end
            default: begin
                for (int i = 0; i < 3; i++) step($sformatf("fault_op%0d", o), rnd, B_FAULT);
                do_reset();
            end
        endcase
    endtask

    initial begin
        n_reset   = 1'b0;
        op        = '0;
        z_flag    = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_eq("reset_state", outs, E_FETCH);
        @(posedge clock);
        #1;
        n_reset = 1'b1;

        run_instr(0, 1'b0, 0, 0);   // LOAD, no waits: 6 cycles
        run_instr(1, 1'b0, 0, 3);   // STORE, 3 write waits: 9 cycles
        run_instr(6, 1'b0, 0, 0);   // BNE taken
        run_instr(6, 1'b1, 1, 2);   // BNE not taken, z toggling during wait
        run_instr(7, 1'b0, 0, 0);   // BEQ not taken
        run_instr(7, 1'b1, 0, 1);   // BEQ taken
        for (int o = 2; o <= 5; o++) run_instr(o, 1'b0, o - 2, 5 - o);
        run_instr(8, 1'b0, 2, 0);   // JMP
        run_instr(9, 1'b0, 0, 0);   // NOP
        run_instr(12, 1'b0, 0, 0);
        run_instr(10, 1'b0, 1, 0);
        run_instr(14, 1'b0, 0, 0);
        run_instr(15, 1'b0, 0, 0);
        run_instr(0, 1'b0, 3, 3);

        // Reset pulsed in the middle of an EX_RD wait.
        op = 4'd2;
        step("mid_fetch", 1'b1, E_FETCH);
        step("mid_frd", 1'b1, E_RD);
        step("mid_fir", 1'b1, E_FIR);
        step("mid_decode", 1'b1, E_DEC);
        step("mid_exrd_wait", 1'b0, E_RD);
        step("mid_exrd_wait", 1'b0, E_RD);
        mem_ready = 1'b0;
        check_eq("mid_exrd_hold", outs, E_RD);
        #2;
        n_reset = 1'b0;
        #1;
        check_eq("async_reset", outs, E_FETCH);
        @(posedge clock);
        #1;
        check_eq("reset_held", outs, E_FETCH);
        n_reset = 1'b1;
        run_instr(3, 1'b0, 0, 0);

`ifdef SEQ_TIMEOUT_EN
        // Four waiting F_RD cycles saturate the 2-bit counter.
        op = 4'd9;
        step("wd_fetch", 1'b1, E_FETCH);
        for (int i = 0; i < 4; i++) step("wd_frd_wait", 1'b0, E_RD);
        step("wd_fault", 1'b0, B_FAULT);
        step("wd_fault", 1'b1, B_FAULT);
        do_reset();
        // Ready in the saturating cycle completes normally.
        step("wd_fetch", 1'b1, E_FETCH);
        for (int i = 0; i < 3; i++) step("wd_frd_wait", 1'b0, E_RD);
        step("wd_frd", 1'b1, E_RD);
        step("wd_fir", 1'b0, E_FIR);
        step("wd_decode", 1'b0, E_DEC);
        step("wd_fetch_after", 1'b0, E_FETCH);
`else
        run_instr(0, 1'b0, 20, 20); // unbounded waits without the watchdog
`endif
        run_instr(9, 1'b0, 0, 0);

        @(negedge clock);
        if (expq.size() != 0) check_eq("queue_drained", 19'(expq.size()), 19'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
